control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle instruction sequencer for the 10-bit datapath. It latches one instruction per execute request and steps through T0–T3. In each step it drives the register-file write/read enables and addresses, the ALU operand/result latches, and the external-data bus enable. It sits directly upstream of the register file, produces all of that file's control inputs, and signals completion with a one-cycle DONE pulse.

## Interface
- Parameters: none; opcode, step and ALU-op encodings come from the shared package.
- CLKb  in  1  system clock; the controller updates on the rising edge, the register file acts on the falling edge.
- RSTb  in  1  reset, asynchronous, active-low.
- INSTR  in  10  instruction word: [3:0] opcode, [5:4] Rx, [7:6] Ry, [9:8] reserved (ignored).
- PEXEC  in  1  execute request, sampled in T0 only.
- ENW, ENR0, ENR1  out  1 each  register-file write and read enables.
- WRA, RDA0, RDA1  out  2 each  register-file write and read addresses.
- EXT  out  1  drive external data onto the bus (LOAD).
- LDA  out  1  latch ALU operand A from Q0.
- LDG  out  1  latch ALU result.
- GOUT  out  1  drive the ALU result onto the bus.
- ALUOP  out  3  ALU function select.
- DONE  out  1  last step of the instruction, one cycle.
- ILLEGAL  out  1  undefined opcode, one cycle, same cycle as DONE.

## Operation
- Opcodes:
  - LOAD 0000: Rx ← ext.
  - MOV 0001: Rx ← Ry.
  - ADD 0010: Rx ← Rx+Ry.
  - SUB 0011: Rx ← Rx−Ry.
  - XOR 0100: Rx ← Rx^Ry (optional, see Configuration).
  - INV 0101: Rx ← ~Ry.
  - All others: illegal.
- T0 (idle):
  - All outputs 0.
  - If PEXEC=1: latch INSTR into IR, go to T1.
- LOAD, T1: EXT=1, ENW=1, WRA=Rx, DONE=1, then T0.
- MOV, T1: ENR1=1, RDA1=Ry, ENW=1, WRA=Rx, DONE=1, then T0.
- ADD/SUB/XOR:
  - T1: ENR0=1, RDA0=Rx, LDA=1.
  - T2: ENR1=1, RDA1=Ry, ALUOP=op, LDG=1.
  - T3: GOUT=1, ENW=1, WRA=Rx, DONE=1, then T0.
- INV:
  - T1: ENR1=1, RDA1=Ry, ALUOP=INV, LDG=1.
  - T2: GOUT=1, ENW=1, WRA=Rx, DONE=1, then T0.
- Illegal opcode, T1: DONE=1, ILLEGAL=1, no enables asserted, then T0.
- Outputs are decoded only from the registered step and the registered IR; INSTR changing mid-instruction has no effect.
- Unused address outputs are 0 whenever their enable is 0.

## Timing
- Reset, asynchronous: step=T0, IR=0, every output 0. Reset mid-instruction aborts it with no ENW, DONE or ILLEGAL.
- Latency from PEXEC sampled high to DONE:
  - LOAD, MOV, illegal: 1 cycle.
  - INV: 2 cycles.
  - ADD, SUB, XOR: 3 cycles.
- Outputs are stable from the rising edge, so the register file's falling-edge write and registered Q0 see settled controls.
  - Q0 requested in T1 is valid from T1's falling edge onward.
  - LDA captures Q0 on the next rising edge.
- PEXEC while not in T0 is ignored; there is no queuing.
- PEXEC held high continuously gives back-to-back execution: DONE cycle, one T0 cycle, then the next T1.
- Rx equal to Ry is legal. Reads precede the write, so ADD R1,R1 doubles R1.

## Configuration
- CONTROL_UNIT_XOR_EN defined: opcode 0100 executes XOR on the ADD/SUB three-step path with ALUOP=XOR.
- Macro undefined: opcode 0100 is illegal (1 cycle, DONE+ILLEGAL, no write), and the XOR ALUOP encoding is never driven.

## Structure
- Package blueberry_pkg holds:
  - opcode_t enum (4 bits);
  - step_t enum T0–T3;
  - alu_op_t enum (3 bits: ADD, SUB, XOR, INV, PASS);
  - field-position constants for opcode, Rx and Ry.
- Sub-module instr_decode: combinational; IR in, decoded class (load/mov/alu3/alu2/illegal) plus Rx, Ry and ALUOP out.
- control_unit holds the step register, the IR, and the output decode.

## Test plan
- Reset, then hold RSTb=0 for 3 cycles → every output 0 and step T0; assert RSTb during ADD T2 → no ENW, and the next PEXEC starts a fresh T1.
- LOAD R2 (INSTR=10'b00_00_10_0000), PEXEC=1 → next cycle EXT=1, ENW=1, WRA=2, DONE=1; with external data 10'h155, R2 reads back 10'h155.
- MOV R3←R1 with R1=10'h0AA → one cycle with ENR1=1, RDA1=1, ENW=1, WRA=3; R3=10'h0AA.
- ADD R0←R0+R3 with R0=5, R3=7 → T1 LDA=1/RDA0=0, T2 LDG=1/RDA1=3/ALUOP=ADD, T3 ENW=1/WRA=0/DONE=1; R0=12.
- Opcode 4'b1111 → DONE=1 and ILLEGAL=1 in the same cycle, ENW never high; repeat with 0100 both with and without CONTROL_UNIT_XOR_EN.
- PEXEC held high across an ADD then a SUB → a PEXEC pulse in T2 is ignored, exactly one T0 cycle between the two DONE pulses, and INSTR toggling during T1–T3 does not alter addresses.

Source files
------------

// File: rtl/blueberry_pkg.sv
// rtl/blueberry_pkg.sv - shared encodings for the 10-bit datapath sequencer
package blueberry_pkg;

    localparam int INSTR_W = 10;
    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 4;
    localparam int RX_LSB  = 4;
    localparam int RY_LSB  = 6;
    localparam int REG_W   = 2;

    typedef enum logic [3:0] {
        OP_LOAD = 4'b0000,
        OP_MOV  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_INV  = 4'b0101
    } opcode_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    // PASS is zero so an idle controller drives ALUOP low.
    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_XOR  = 3'd3,
        ALU_INV  = 3'd4
    } alu_op_t;

    typedef enum logic [2:0] {
        CLS_LOAD    = 3'd0,
        CLS_MOV     = 3'd1,
        CLS_ALU3    = 3'd2,
        CLS_ALU2    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } instr_class_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational IR decode; XOR opcode legal only with CONTROL_UNIT_XOR_EN
module instr_decode
    import blueberry_pkg::*;
(
    input  logic [INSTR_W-1:0] i_ir,
    output instr_class_t       o_class,
    output logic [REG_W-1:0]   o_rx,
    output logic [REG_W-1:0]   o_ry,
    output alu_op_t            o_alu_op
);

    logic [OPC_W-1:0] w_opcode;
    logic             w_unused_rsvd;

    assign w_opcode      = i_ir[OPC_LSB +: OPC_W];
    assign o_rx          = i_ir[RX_LSB +: REG_W];
    assign o_ry          = i_ir[RY_LSB +: REG_W];
    assign w_unused_rsvd = ^i_ir[INSTR_W-1:RY_LSB+REG_W];

    always_comb begin
        o_class  = CLS_ILLEGAL;
        o_alu_op = ALU_PASS;
        case (w_opcode)
            OP_LOAD: o_class = CLS_LOAD;
            OP_MOV:  o_class = CLS_MOV;
            OP_ADD: begin
                o_class  = CLS_ALU3;
                o_alu_op = ALU_ADD;
            end
            OP_SUB: begin
                o_class  = CLS_ALU3;
                o_alu_op = ALU_SUB;
            end
`ifdef CONTROL_UNIT_XOR_EN
            OP_XOR: begin
                o_class  = CLS_ALU3;
                o_alu_op = ALU_XOR;
            end
`endif
            OP_INV: begin
                o_class  = CLS_ALU2;
                o_alu_op = ALU_INV;
            end
            default: o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - T0..T3 instruction sequencer driving register-file and ALU controls
// Optional XOR instruction enabled by CONTROL_UNIT_XOR_EN.
module control_unit
    import blueberry_pkg::*;
(
    input  logic               CLKb,
    input  logic               RSTb,
    input  logic [INSTR_W-1:0] INSTR,
    input  logic               PEXEC,
    output logic               ENW,
    output logic               ENR0,
    output logic               ENR1,
    output logic [REG_W-1:0]   WRA,
    output logic [REG_W-1:0]   RDA0,
    output logic [REG_W-1:0]   RDA1,
    output logic               EXT,
    output logic               LDA,
    output logic               LDG,
    output logic               GOUT,
    output logic [2:0]         ALUOP,
    output logic               DONE,
    output logic               ILLEGAL
);

    step_t              r_step;
    step_t              w_step_next;
    logic [INSTR_W-1:0] r_ir;
    instr_class_t       w_class;
    logic [REG_W-1:0]   w_rx;
    logic [REG_W-1:0]   w_ry;
    alu_op_t            w_alu_op;

    instr_decode u_decode (
        .i_ir     (r_ir),
        .o_class  (w_class),
        .o_rx     (w_rx),
        .o_ry     (w_ry),
        .o_alu_op (w_alu_op)
    );

    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            r_step <= T0;
            r_ir   <= '0;
        end else begin
            r_step <= w_step_next;
            if (r_step == T0 && PEXEC) begin
                r_ir <= INSTR;
            end
        end
    end

    // Outputs depend only on r_step and r_ir, so they settle right after the rising edge.
    always_comb begin
        w_step_next = r_step;
        ENW     = 1'b0;
        ENR0    = 1'b0;
        ENR1    = 1'b0;
        WRA     = '0;
        RDA0    = '0;
        RDA1    = '0;
        EXT     = 1'b0;
        LDA     = 1'b0;
        LDG     = 1'b0;
        GOUT    = 1'b0;
        ALUOP   = ALU_PASS;
        DONE    = 1'b0;
        ILLEGAL = 1'b0;
        case (r_step)
            T0: begin
                if (PEXEC) w_step_next = T1;
            end
            T1: begin
                w_step_next = T0;
                case (w_class)
                    CLS_LOAD: begin
                        EXT  = 1'b1;
                        ENW  = 1'b1;
                        WRA  = w_rx;
                        DONE = 1'b1;
                    end
                    CLS_MOV: begin
                        ENR1 = 1'b1;
                        RDA1 = w_ry;
                        ENW  = 1'b1;
                        WRA  = w_rx;
                        DONE = 1'b1;
                    end
                    CLS_ALU3: begin
                        ENR0        = 1'b1;
                        RDA0        = w_rx;
                        LDA         = 1'b1;
                        w_step_next = T2;
                    end
                    CLS_ALU2: begin
                        ENR1        = 1'b1;
                        RDA1        = w_ry;
                        ALUOP       = w_alu_op;
                        LDG         = 1'b1;
                        w_step_next = T2;
                    end
                    default: begin
                        DONE    = 1'b1;
                        ILLEGAL = 1'b1;
                    end
                endcase
            end
            T2: begin
                w_step_next = T0;
                if (w_class == CLS_ALU3) begin
                    ENR1        = 1'b1;
                    RDA1        = w_ry;
                    ALUOP       = w_alu_op;
                    LDG         = 1'b1;
                    w_step_next = T3;
                end else if (w_class == CLS_ALU2) begin
                    GOUT = 1'b1;
                    ENW  = 1'b1;
                    WRA  = w_rx;
                    DONE = 1'b1;
                end
            end
            T3: begin
                w_step_next = T0;
                GOUT = 1'b1;
                ENW  = 1'b1;
                WRA  = w_rx;
                DONE = 1'b1;
            end
            default: w_step_next = T0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench with a small register-file/ALU model
module tb_control_unit;
    import blueberry_pkg::*;

    logic       CLKb = 1'b0;
    logic       RSTb = 1'b0;
    logic [9:0] INSTR = '0;
    logic       PEXEC = 1'b0;
    logic       ENW, ENR0, ENR1, EXT, LDA, LDG, GOUT, DONE, ILLEGAL;
    logic [1:0] WRA, RDA0, RDA1;
    logic [2:0] ALUOP;

    int checks = 0;
    int errors = 0;

    logic [9:0] ext_data = '0;
    logic [9:0] rf [4];
    logic [9:0] q0, a_reg, g_reg, bus;
    logic [17:0] outs;

    control_unit dut (
        .CLKb(CLKb), .RSTb(RSTb), .INSTR(INSTR), .PEXEC(PEXEC),
        .ENW(ENW), .ENR0(ENR0), .ENR1(ENR1), .WRA(WRA), .RDA0(RDA0), .RDA1(RDA1),
        .EXT(EXT), .LDA(LDA), .LDG(LDG), .GOUT(GOUT), .ALUOP(ALUOP),
        .DONE(DONE), .ILLEGAL(ILLEGAL)
    );

    always #5 CLKb = ~CLKb;

    assign outs = {ENW, ENR0, ENR1, WRA, RDA0, RDA1, EXT, LDA, LDG, GOUT, ALUOP, DONE, ILLEGAL};
    assign bus  = EXT ? ext_data : (GOUT ? g_reg : (ENR1 ? rf[RDA1] : 10'h000));

    always @(negedge CLKb) begin
        if (ENR0) q0 <= rf[RDA0];
        if (ENW)  rf[WRA] <= bus;
    end

    always @(posedge CLKb) begin
        if (LDA) a_reg <= q0;
        if (LDG) begin
            case (ALUOP)
                3'd1:    g_reg <= a_reg + rf[RDA1];
                3'd2:    g_reg <= a_reg - rf[RDA1];
                3'd3:    g_reg <= a_reg ^ rf[RDA1];
                3'd4:    g_reg <= ~rf[RDA1];
                default: g_reg <= rf[RDA1];
            endcase
        end
    end

    task automatic tick();
        @(posedge CLKb);
        #1;
    endtask

    task automatic issue(input logic [9:0] instr);
        INSTR = instr;
        PEXEC = 1'b1;
        tick();
        PEXEC = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] rx, input logic [9:0] data);
        ext_data = data;
        issue({4'b0000, rx, 4'b0000});
        tick();
    endtask

    task automatic test_reset();
        RSTb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (outs !== 18'h0 || dut.r_step !== T0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d outs=%h step=%0d required outs=0 step=0", i, outs, dut.r_step);
            end
        end
        RSTb = 1'b1;
        tick();
        checks++;
        if (outs !== 18'h0) begin
            errors++;
            $display("FAIL reset_idle outs=%h required 0", outs);
        end
    endtask

    task automatic test_load();
        ext_data = 10'h155;
        issue(10'b00_00_10_0000);
        checks++;
        if (outs !== {1'b1, 2'b00, 2'd2, 4'b0, 1'b1, 3'b0, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL load_t1 outs=%h", outs);
        end
        tick();
        checks++;
        if (rf[2] !== 10'h155 || outs !== 18'h0) begin
            errors++;
            $display("FAIL load_data R2=%h outs=%h required R2=155 outs=0", rf[2], outs);
        end
    endtask

    task automatic test_mov();
        do_load(2'd1, 10'h0AA);
        issue(10'b00_01_11_0001);
        checks++;
        if (ENR1 !== 1'b1 || RDA1 !== 2'd1 || ENW !== 1'b1 || WRA !== 2'd3 || DONE !== 1'b1 || EXT !== 1'b0) begin
            errors++;
            $display("FAIL mov_t1 outs=%h", outs);
        end
        tick();
        checks++;
        if (rf[3] !== 10'h0AA) begin
            errors++;
            $display("FAIL mov_data R3=%h required 0aa", rf[3]);
        end
    endtask

    task automatic test_add();
        do_load(2'd0, 10'd5);
        do_load(2'd3, 10'd7);
        issue(10'b00_11_00_0010);
        checks++;
        if (LDA !== 1'b1 || ENR0 !== 1'b1 || RDA0 !== 2'd0 || ENW !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL add_t1 outs=%h", outs);
        end
        tick();
        checks++;
        if (LDG !== 1'b1 || ENR1 !== 1'b1 || RDA1 !== 2'd3 || ALUOP !== 3'd1 || ENW !== 1'b0 || LDA !== 1'b0) begin
            errors++;
            $display("FAIL add_t2 outs=%h", outs);
        end
        tick();
        checks++;
        if (ENW !== 1'b1 || WRA !== 2'd0 || DONE !== 1'b1 || GOUT !== 1'b1 || ILLEGAL !== 1'b0) begin
            errors++;
            $display("FAIL add_t3 outs=%h", outs);
        end
        tick();
        checks++;
        if (rf[0] !== 10'd12 || outs !== 18'h0) begin
            errors++;
            $display("FAIL add_data R0=%h outs=%h required R0=00c outs=0", rf[0], outs);
        end
        issue(10'b00_01_01_0010);
        tick();
        tick();
        tick();
        checks++;
        if (rf[1] !== 10'h154) begin
            errors++;
            $display("FAIL add_self R1=%h required 154", rf[1]);
        end
    endtask

    task automatic test_illegal();
        logic [9:0] r2_before;
        r2_before = rf[2];
        issue(10'b00_00_10_1111);
        checks++;
        if (outs !== 18'b11) begin
            errors++;
            $display("FAIL illegal_1111 outs=%h required 00003", outs);
        end
        tick();
        issue(10'b00_10_10_0100);
`ifdef CONTROL_UNIT_XOR_EN
        checks++;
        if (LDA !== 1'b1 || DONE !== 1'b0 || ILLEGAL !== 1'b0) begin
            errors++;
            $display("FAIL xor_t1 outs=%h", outs);
        end
        tick();
        checks++;
        if (ALUOP !== 3'd3 || LDG !== 1'b1) begin
            errors++;
            $display("FAIL xor_t2 outs=%h", outs);
        end
        tick();
        tick();
        checks++;
        if (rf[2] !== 10'h000) begin
            errors++;
            $display("FAIL xor_data R2=%h required 000", rf[2]);
        end
`else
        checks++;
        if (outs !== 18'b11) begin
            errors++;
            $display("FAIL illegal_0100 outs=%h required 00003", outs);
        end
        tick();
        checks++;
        if (rf[2] !== r2_before || outs !== 18'h0) begin
            errors++;
            $display("FAIL illegal_nowrite R2=%h outs=%h required R2=%h outs=0", rf[2], outs, r2_before);
        end
`endif
    endtask

    task automatic test_inv();
        issue(10'b00_11_10_0101);
        checks++;
        if (LDG !== 1'b1 || ALUOP !== 3'd4 || RDA1 !== 2'd3 || ENW !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL inv_t1 outs=%h", outs);
        end
        tick();
        checks++;
        if (GOUT !== 1'b1 || ENW !== 1'b1 || WRA !== 2'd2 || DONE !== 1'b1) begin
            errors++;
            $display("FAIL inv_t2 outs=%h", outs);
        end
        tick();
        checks++;
        if (rf[2] !== 10'h3F8) begin
            errors++;
            $display("FAIL inv_data R2=%h required 3f8", rf[2]);
        end
    endtask

    task automatic test_reset_mid();
        issue(10'b00_11_00_0010);
        tick();
        #1 RSTb = 1'b0;
        #1;
        checks++;
        if (outs !== 18'h0 || dut.r_step !== T0) begin
            errors++;
            $display("FAIL reset_mid outs=%h step=%0d required 0", outs, dut.r_step);
        end
        tick();
        RSTb = 1'b1;
        checks++;
        if (rf[0] !== 10'd12) begin
            errors++;
            $display("FAIL reset_mid_nowrite R0=%h required 00c", rf[0]);
        end
        issue(10'b00_11_00_0010);
        checks++;
        if (LDA !== 1'b1 || RDA0 !== 2'd0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_fresh_t1 outs=%h", outs);
        end
        tick();
        tick();
        tick();
        checks++;
        if (rf[0] !== 10'd19) begin
            errors++;
            $display("FAIL reset_fresh_data R0=%h required 013", rf[0]);
        end
    endtask

    task automatic test_pexec_ignored();
        issue(10'b00_11_00_0011);
        tick();
        PEXEC = 1'b1;
        INSTR = 10'b00_00_10_0000;
        tick();
        PEXEC = 1'b0;
        checks++;
        if (DONE !== 1'b1 || WRA !== 2'd0 || EXT !== 1'b0) begin
            errors++;
            $display("FAIL pexec_t3 outs=%h", outs);
        end
        tick();
        tick();
        checks++;
        if (outs !== 18'h0 || dut.r_step !== T0 || rf[0] !== 10'd12) begin
            errors++;
            $display("FAIL pexec_noqueue outs=%h step=%0d R0=%h required 0/0/00c", outs, dut.r_step, rf[0]);
        end
    endtask

    task automatic test_back_to_back();
        INSTR = 10'b00_11_00_0010;
        PEXEC = 1'b1;
        tick();
        INSTR = 10'b00_11_01_0011;
        checks++;
        if (LDA !== 1'b1 || RDA0 !== 2'd0) begin
            errors++;
            $display("FAIL b2b_add_t1 outs=%h", outs);
        end
        tick();
        tick();
        checks++;
        if (DONE !== 1'b1 || WRA !== 2'd0) begin
            errors++;
            $display("FAIL b2b_add_done outs=%h", outs);
        end
        tick();
        checks++;
        if (outs !== 18'h0 || dut.r_step !== T0) begin
            errors++;
            $display("FAIL b2b_gap outs=%h step=%0d required 0", outs, dut.r_step);
        end
        tick();
        INSTR = 10'h3FF;
        checks++;
        if (LDA !== 1'b1 || RDA0 !== 2'd1) begin
            errors++;
            $display("FAIL b2b_sub_t1 outs=%h", outs);
        end
        tick();
        INSTR = 10'h2C6;
        checks++;
        if (RDA1 !== 2'd3 || ALUOP !== 3'd2 || LDG !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sub_t2 outs=%h", outs);
        end
        tick();
        PEXEC = 1'b0;
        checks++;
        if (DONE !== 1'b1 || WRA !== 2'd1 || ENW !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sub_done outs=%h", outs);
        end
        tick();
        checks++;
        if (rf[0] !== 10'd19 || rf[1] !== 10'h14D) begin
            errors++;
            $display("FAIL b2b_data R0=%h R1=%h required 013 14d", rf[0], rf[1]);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_mov();
        test_add();
        test_illegal();
        test_inv();
        test_reset_mid();
        test_pexec_ignored();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
